// File: rtl/stall_flush_stage.sv
// Stage-boundary register that obeys the global stall/flush broadcast: holds on stall,
// inserts a run of bubbles on flush, and keeps stall-duration and bubble statistics.
module stall_flush_stage #(
  parameter int DATA_W       = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 8,
  parameter int TIMEOUT      = 100
) (
  input  logic              s_clk,
  input  logic              s_rst,
  input  logic              i_stall,
  input  logic              i_flush,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_timeout_clr,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_ce,
  output logic              o_flush_busy,
  output logic [CNT_W-1:0]  o_stall_cnt,
  output logic              o_timeout,
  output logic [CNT_W-1:0]  o_bubble_cnt
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic [3:0]       FC_RELOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TO_VAL    = CNT_W'(TIMEOUT);

  state_t              r_state, w_state_nxt;
  logic [3:0]          r_fcnt, w_fcnt_nxt;
  logic                r_valid, w_valid_nxt;
  logic [DATA_W-1:0]   r_data, w_data_nxt;
  logic                r_busy, w_busy_nxt;
  logic [CNT_W-1:0]    r_stall_cnt, w_stall_cnt_nxt;
  logic                r_timeout, w_timeout_nxt;
  logic [CNT_W-1:0]    r_bubble_cnt, w_bubble_nxt;
  logic                w_ce;

  // State register
  always_ff @(posedge s_clk or negedge s_rst) begin
    if (!s_rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: stall beats flush beats normal flow outside FLUSH
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN, ST_HOLD: begin
        if (i_stall) begin
          w_state_nxt = ST_HOLD;
        end else if (i_flush) begin
          w_state_nxt = ST_FLUSH;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (i_flush) begin
          w_state_nxt = ST_FLUSH;
        end else if (r_fcnt == 4'd0) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_FLUSH;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // Output logic: upstream advance enable, forced low while in reset
  always_comb begin
    w_ce = s_rst && (r_state == ST_RUN) && !i_stall && !i_flush;
  end

  // Datapath next values; the exit edge of FLUSH captures like RUN so no extra bubble appears
  always_comb begin
    w_valid_nxt     = r_valid;
    w_data_nxt      = r_data;
    w_busy_nxt      = r_busy;
    w_stall_cnt_nxt = r_stall_cnt;
    w_bubble_nxt    = r_bubble_cnt;
    w_fcnt_nxt      = r_fcnt;
    case (r_state)
      ST_RUN, ST_HOLD: begin
        if (i_stall) begin
          if (r_state == ST_RUN) begin
            w_stall_cnt_nxt = CNT_ONE;
          end else if (r_stall_cnt == CNT_MAX) begin
            w_stall_cnt_nxt = CNT_MAX;
          end else begin
            w_stall_cnt_nxt = r_stall_cnt + CNT_ONE;
          end
        end else if (i_flush) begin
          w_valid_nxt     = 1'b0;
          w_data_nxt      = {DATA_W{1'b0}};
          w_fcnt_nxt      = FC_RELOAD;
          w_bubble_nxt    = r_bubble_cnt + CNT_ONE;
          w_busy_nxt      = 1'b1;
          w_stall_cnt_nxt = {CNT_W{1'b0}};
        end else begin
          w_valid_nxt     = i_valid;
          w_data_nxt      = i_valid ? i_data : r_data;
          w_stall_cnt_nxt = {CNT_W{1'b0}};
        end
      end
      ST_FLUSH: begin
        if (i_flush) begin
          w_valid_nxt  = 1'b0;
          w_data_nxt   = {DATA_W{1'b0}};
          w_fcnt_nxt   = FC_RELOAD;
          w_bubble_nxt = r_bubble_cnt + CNT_ONE;
        end else if (r_fcnt == 4'd0) begin
          w_busy_nxt  = 1'b0;
          w_valid_nxt = i_valid;
          w_data_nxt  = i_valid ? i_data : r_data;
        end else begin
          w_valid_nxt  = 1'b0;
          w_data_nxt   = {DATA_W{1'b0}};
          w_fcnt_nxt   = r_fcnt - 4'd1;
          w_bubble_nxt = r_bubble_cnt + CNT_ONE;
        end
      end
      default: begin
        w_valid_nxt = r_valid;
      end
    endcase
  end

  // Watchdog: set when the stall count first reaches the threshold; clear has priority
  always_comb begin
    if (i_timeout_clr) begin
      w_timeout_nxt = 1'b0;
    end else if ((w_stall_cnt_nxt == TO_VAL) && (r_stall_cnt != TO_VAL)) begin
      w_timeout_nxt = 1'b1;
    end else begin
      w_timeout_nxt = r_timeout;
    end
  end

  // Stage register, flush counter and statistics
  always_ff @(posedge s_clk or negedge s_rst) begin
    if (!s_rst) begin
      r_fcnt       <= 4'd0;
      r_valid      <= 1'b0;
      r_data       <= {DATA_W{1'b0}};
      r_busy       <= 1'b0;
      r_stall_cnt  <= {CNT_W{1'b0}};
      r_timeout    <= 1'b0;
      r_bubble_cnt <= {CNT_W{1'b0}};
    end else begin
      r_fcnt       <= w_fcnt_nxt;
      r_valid      <= w_valid_nxt;
      r_data       <= w_data_nxt;
      r_busy       <= w_busy_nxt;
      r_stall_cnt  <= w_stall_cnt_nxt;
      r_timeout    <= w_timeout_nxt;
      r_bubble_cnt <= w_bubble_nxt;
    end
  end

  assign o_valid      = r_valid;
  assign o_data       = r_data;
  assign o_ce         = w_ce;
  assign o_flush_busy = r_busy;
  assign o_stall_cnt  = r_stall_cnt;
  assign o_timeout    = r_timeout;
  assign o_bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_stall_flush_stage.sv
// Scoreboard bench for stall_flush_stage: a behavioural model queues the expected
// post-edge outputs, and a monitor compares them after every rising edge.
module tb_stall_flush_stage;
  localparam int DW = 32;
  localparam int FC = 2;
  localparam int CW = 8;
  localparam int TO = 4;

  logic          s_clk = 1'b0;
  logic          s_rst = 1'b0;
  logic          i_stall = 1'b0, i_flush = 1'b0, i_valid = 1'b0, i_timeout_clr = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic          o_valid, o_ce, o_flush_busy, o_timeout;
  logic [DW-1:0] o_data;
  logic [CW-1:0] o_stall_cnt, o_bubble_cnt;

  stall_flush_stage #(.DATA_W(DW), .FLUSH_CYCLES(FC), .CNT_W(CW), .TIMEOUT(TO)) dut (
    .s_clk(s_clk), .s_rst(s_rst), .i_stall(i_stall), .i_flush(i_flush),
    .i_valid(i_valid), .i_data(i_data), .i_timeout_clr(i_timeout_clr),
    .o_valid(o_valid), .o_data(o_data), .o_ce(o_ce), .o_flush_busy(o_flush_busy),
    .o_stall_cnt(o_stall_cnt), .o_timeout(o_timeout), .o_bubble_cnt(o_bubble_cnt)
  );

  always #5 s_clk = ~s_clk;

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          busy;
    logic [CW-1:0] sc;
    logic          to;
    logic [CW-1:0] bc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Behavioural model: stall flag, edges left in the current flush, plain integer counters
  bit          m_stalled;
  int          m_pending;
  int          m_stall_cnt;
  bit          m_timeout;
  int          m_bubbles;
  logic        m_valid;
  logic [DW-1:0] m_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_stalled = 0; m_pending = 0; m_stall_cnt = 0; m_timeout = 0;
    m_bubbles = 0; m_valid = 1'b0; m_data = '0;
  endtask

  task automatic bubble();
    m_valid = 1'b0;
    m_data = '0;
    m_bubbles = (m_bubbles + 1) % (1 << CW);
  endtask

  task automatic capture(input logic v, input logic [DW-1:0] d);
    m_valid = v;
    if (v) m_data = d;
  endtask

  task automatic model_step(input logic st, input logic fl, input logic v,
                            input logic [DW-1:0] d, input logic clr);
    int prev_sc;
    prev_sc = m_stall_cnt;
    if (m_pending > 0) begin
      if (fl) begin
        m_pending = FC;
        bubble();
      end else if (m_pending == 1) begin
        m_pending = 0;
        capture(v, d);
      end else begin
        m_pending--;
        bubble();
      end
    end else if (st) begin
      if (m_stalled) m_stall_cnt = (m_stall_cnt + 1 > (1 << CW) - 1) ? (1 << CW) - 1 : m_stall_cnt + 1;
      else m_stall_cnt = 1;
      m_stalled = 1;
    end else begin
      m_stalled = 0;
      m_stall_cnt = 0;
      if (fl) begin
        m_pending = FC;
        bubble();
      end else begin
        capture(v, d);
      end
    end
    if (clr) m_timeout = 0;
    else if (m_stall_cnt == TO && prev_sc != TO) m_timeout = 1;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.v = m_valid; e.d = m_data; e.busy = (m_pending > 0);
    e.sc = CW'(m_stall_cnt); e.to = m_timeout; e.bc = CW'(m_bubbles);
    return e;
  endfunction

  // One clock of stimulus: drive on the falling edge, queue the expectation, check o_ce
  task automatic cycle(input logic st, input logic fl, input logic v,
                       input logic [DW-1:0] d, input logic clr);
    logic exp_ce;
    @(negedge s_clk);
    s_rst = 1'b1;
    i_stall = st; i_flush = fl; i_valid = v; i_data = d; i_timeout_clr = clr;
    exp_ce = !m_stalled && (m_pending == 0) && !st && !fl;
    model_step(st, fl, v, d, clr);
    q.push_back(model_out());
    #1;
    chk("o_ce", 64'(o_ce), 64'(exp_ce));
  endtask

  // Assert reset between edges and confirm the asynchronous clear before the next edge
  task automatic rst_cycle();
    exp_t z;
    @(negedge s_clk);
    #2;
    s_rst = 1'b0;
    i_stall = $urandom_range(0, 1); i_flush = $urandom_range(0, 1);
    i_valid = 1'b1; i_data = $urandom; i_timeout_clr = 1'b0;
    #1;
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_data", 64'(o_data), 64'd0);
    chk("rst_ce", 64'(o_ce), 64'd0);
    chk("rst_busy", 64'(o_flush_busy), 64'd0);
    chk("rst_stall_cnt", 64'(o_stall_cnt), 64'd0);
    chk("rst_timeout", 64'(o_timeout), 64'd0);
    chk("rst_bubble_cnt", 64'(o_bubble_cnt), 64'd0);
    model_reset();
    z = model_out();
    q.push_back(z);
  endtask

  // Monitor: after each rising edge compare the registered outputs with the queued expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge s_clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("o_valid", 64'(o_valid), 64'(e.v));
        chk("o_data", 64'(o_data), 64'(e.d));
        chk("o_flush_busy", 64'(o_flush_busy), 64'(e.busy));
        chk("o_stall_cnt", 64'(o_stall_cnt), 64'(e.sc));
        chk("o_timeout", 64'(o_timeout), 64'(e.to));
        chk("o_bubble_cnt", 64'(o_bubble_cnt), 64'(e.bc));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  initial begin
    model_reset();
    rst_cycle();
    rst_cycle();
    // streaming, then a 5-cycle stall holding 0x22
    cycle(1'b0, 1'b0, 1'b1, 32'h11, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'h22, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b1, 32'h99, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'h33, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 32'h44, 1'b0);
    // isolated flush
    cycle(1'b0, 1'b1, 1'b1, 32'h55, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'h66, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'h77, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'h88, 1'b0);
    // stall+flush together, then flush alone, with stall ignored during the bubbles
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b1, 32'hA0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 32'hA1, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 32'hA2, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 32'hA3, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'hA4, 1'b0);
    // watchdog set, sticky after stall, then cleared
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'hB0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'hB1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'hB2, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 32'hB3, 1'b0);
    // reset after one bubble of a flush
    cycle(1'b0, 1'b1, 1'b1, 32'hC0, 1'b0);
    rst_cycle();
    cycle(1'b0, 1'b0, 1'b1, 32'hC1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'hC2, 1'b0);
    // long stall to reach counter saturation, with clear and set in the same cycle
    for (int i = 0; i < 260; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, (i == 3) ? 1'b1 : 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'hD0, 1'b1);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst_cycle();
      end else begin
        cycle(($urandom_range(0, 99) < 30) ? 1'b1 : 1'b0,
              ($urandom_range(0, 99) < 8) ? 1'b1 : 1'b0,
              1'($urandom_range(0, 1)), $urandom,
              ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0);
      end
    end
    @(posedge s_clk);
    #3;
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stall_flush_stage.md
Name: stall_flush_stage

Overview:
- Receiving end of the pipeline stall/flush broadcast: one instance sits at each pipeline stage boundary and acts on the registered global stall and flush strobes.
- Holds the stage register on stall and inserts a programmable run of bubbles on flush.
- Gates upstream advance via a clock-enable.
- Provides stall-duration watchdog and bubble accounting for debug and performance counters.

Parameters:
DATA_W, 32, width of the stage payload register
FLUSH_CYCLES, 2, number of bubble cycles inserted per flush (legal range 1..15)
CNT_W, 8, width of the stall-duration and bubble counters
TIMEOUT, 100, stall-duration threshold for the watchdog (legal range 1..2^CNT_W-1)

Ports:
s_clk  input  1  clock, rising edge
s_rst  input  1  asynchronous active-low reset
i_stall  input  1  global stall strobe from the stall aggregator
i_flush  input  1  global flush strobe from the stall aggregator
i_valid  input  1  upstream payload valid
i_data  input  DATA_W  upstream payload
i_timeout_clr  input  1  clears sticky o_timeout
o_valid  output  1  stage register valid
o_data  output  DATA_W  stage register payload
o_ce  output  1  upstream advance enable (combinational)
o_flush_busy  output  1  high while bubbles are being inserted
o_stall_cnt  output  CNT_W  cycles spent in the current stall
o_timeout  output  1  sticky watchdog flag
o_bubble_cnt  output  CNT_W  total bubbles inserted, wraps modulo 2^CNT_W

Behaviour:
- Reset (s_rst low, asynchronous): state=RUN; all outputs 0 (o_ce stays combinational and equals 1 once s_rst is high with no stall or flush); flush counter 0. Reset mid-stall or mid-flush aborts immediately, with no pending bubbles afterwards.
- FSM states: RUN, HOLD, FLUSH. Priority in RUN and HOLD: stall > flush > normal.
- RUN:
  - i_stall=1: go to HOLD; o_valid and o_data hold; o_stall_cnt<=1.
  - else i_flush=1: go to FLUSH; o_valid<=0; o_data<=0; flush counter<=FLUSH_CYCLES-1; o_bubble_cnt+=1; o_flush_busy<=1.
  - else: o_valid<=i_valid; o_data<=i_data only when i_valid=1, otherwise o_data holds.
- HOLD:
  - i_stall=1: stay; o_valid and o_data hold; o_stall_cnt increments, saturating at 2^CNT_W-1.
  - i_stall=0 and i_flush=1: enter FLUSH exactly as from RUN; o_stall_cnt<=0.
  - i_stall=0 and i_flush=0: return to RUN, capturing i_valid/i_data as in RUN on that same edge; o_stall_cnt<=0.
- FLUSH:
  - i_stall is ignored; bubbles are not held.
  - Each cycle: o_valid<=0, o_data<=0, o_bubble_cnt+=1 (wrapping).
  - i_flush=1 reloads the flush counter to FLUSH_CYCLES-1 and stays in FLUSH.
  - Otherwise, flush counter==0: go to RUN and clear o_flush_busy, with no bubble on that edge; else decrement.
  - Net result: an isolated flush yields exactly FLUSH_CYCLES consecutive o_valid=0 cycles and o_bubble_cnt advances by FLUSH_CYCLES.
- o_ce = (state==RUN) and !i_stall and !i_flush. It is 0 throughout HOLD and FLUSH.
- Watchdog:
  - o_timeout is set on the edge where o_stall_cnt becomes TIMEOUT.
  - It is sticky until i_timeout_clr=1. Clear wins over set in the same cycle.
  - Leaving HOLD does not clear it.
- Latency: one cycle from i_data to o_data in RUN. Stall and flush take effect on the first edge they are sampled high.

Test Plan:
1. Reset, then stream i_valid=1 with i_data=0x11,0x22,0x33 -> o_data shows 0x11,0x22,0x33 one cycle later each; o_ce=1 throughout; o_bubble_cnt=0.
2. In RUN with o_data=0x22, raise i_stall for 5 cycles -> o_data stays 0x22, o_valid stays 1, o_ce=0, o_stall_cnt reaches 5. After i_stall drops, the next edge captures new data and o_stall_cnt=0.
3. Single-cycle i_flush with FLUSH_CYCLES=2 -> exactly 2 cycles of o_valid=0 with o_data=0; o_flush_busy high for 2 cycles; o_bubble_cnt=2; RUN capture resumes on the third edge.
4. i_stall and i_flush high together for 3 cycles, then i_flush only for 1 cycle -> HOLD for 3 cycles (data held), then FLUSH with 2 bubbles; i_stall asserted during FLUSH is ignored.
5. TIMEOUT=4: hold i_stall for 6 cycles -> o_timeout rises on the edge where o_stall_cnt=4 and stays high after the stall ends. Pulse i_timeout_clr -> o_timeout=0 next edge.
6. Assert s_rst low mid-FLUSH (after 1 bubble) -> all outputs 0 immediately. After release, RUN with no remaining bubbles: the first valid input appears one cycle later.
